// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32I encodings for the single-cycle core: opcode,
//                funct3 and funct7 constants, the ALU operation enumeration
//                and the write-back source selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] c_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] c_F3_SLL     = 3'b001;
    localparam logic [2:0] c_F3_SLT     = 3'b010;
    localparam logic [2:0] c_F3_SLTU    = 3'b011;
    localparam logic [2:0] c_F3_XOR     = 3'b100;
    localparam logic [2:0] c_F3_SR      = 3'b101;
    localparam logic [2:0] c_F3_OR      = 3'b110;
    localparam logic [2:0] c_F3_AND     = 3'b111;

    // funct3 for BRANCH
    localparam logic [2:0] c_F3_BEQ     = 3'b000;
    localparam logic [2:0] c_F3_BNE     = 3'b001;
    localparam logic [2:0] c_F3_BLT     = 3'b100;
    localparam logic [2:0] c_F3_BGE     = 3'b101;
    localparam logic [2:0] c_F3_BLTU    = 3'b110;
    localparam logic [2:0] c_F3_BGEU    = 3'b111;

    // funct3 for LOAD / STORE (access width and extension)
    localparam logic [2:0] c_F3_B       = 3'b000;
    localparam logic [2:0] c_F3_H       = 3'b001;
    localparam logic [2:0] c_F3_W       = 3'b010;
    localparam logic [2:0] c_F3_BU      = 3'b100;
    localparam logic [2:0] c_F3_HU      = 3'b101;

    // funct7
    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_PC4  = 2'd1,
        WB_LOAD = 2'd2
    } wb_sel_t;

    // Maps funct3 plus the funct7[5] "alternate" bit onto an ALU operation.
    // The alternate bit only matters for ADD/SUB and SRL/SRA.
    function automatic alu_op_t alu_op_decode(input logic [2:0] funct3,
                                              input logic       alt);
        alu_op_t op;
        case (funct3)
            c_F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            c_F3_SLL:     op = ALU_SLL;
            c_F3_SLT:     op = ALU_SLT;
            c_F3_SLTU:    op = ALU_SLTU;
            c_F3_XOR:     op = ALU_XOR;
            c_F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            c_F3_OR:      op = ALU_OR;
            default:      op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_alu.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_alu
//  Description : Combinational integer ALU for the RV32I core (including the
//                low half of MUL).
//  Ports       : i_a, i_b  - 32-bit operands
//                i_op      - operation select (alu_op_t)
//                o_result  - 32-bit result
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_op_t     i_op,
    output logic [31:0] o_result
);

    logic [4:0] w_shamt;

    // Shift amounts only ever use the low five bits of the second operand.
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = 32'd0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {31'd0, i_a < i_b};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_MUL:  o_result = i_a * i_b;
            default:  o_result = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_cpu_core
//  Description : Single-cycle RV32I core with MUL. Every instruction fetches,
//                decodes, executes, accesses memory and writes back in one
//                clock. Unsupported encodings retire as NOPs.
//  Ports       : clk            - rising-edge clock
//                rst            - synchronous, active-low reset
//                instr_addr_o   - fetch address (the PC)
//                instr_data_i   - instruction word, combinational return
//                data_addr_o    - load/store byte address (rs1 + imm)
//                data_wdata_o   - store data, replicated across lanes
//                data_we_o      - per-byte write enables
//                data_rdata_i   - load word, combinational return
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_cpu_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_data_i,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic [3:0]  data_we_o,
    input  logic [31:0] data_rdata_i
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = instr_data_i[6:0];
    assign w_rd     = instr_data_i[11:7];
    assign w_funct3 = instr_data_i[14:12];
    assign w_rs1    = instr_data_i[19:15];
    assign w_rs2    = instr_data_i[24:20];
    assign w_funct7 = instr_data_i[31:25];

    assign w_imm_i = {{20{instr_data_i[31]}}, instr_data_i[31:20]};
    assign w_imm_s = {{20{instr_data_i[31]}}, instr_data_i[31:25],
                      instr_data_i[11:7]};
    assign w_imm_b = {{19{instr_data_i[31]}}, instr_data_i[31], instr_data_i[7],
                      instr_data_i[30:25], instr_data_i[11:8], 1'b0};
    assign w_imm_u = {instr_data_i[31:12], 12'd0};
    assign w_imm_j = {{11{instr_data_i[31]}}, instr_data_i[31],
                      instr_data_i[19:12], instr_data_i[20],
                      instr_data_i[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Register file read (x0 hard-wired to zero)
    // ------------------------------------------------------------------
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    // ------------------------------------------------------------------
    // Address generation. The same rs1 + imm sum serves loads, stores and
    // the JALR target; only stores use the S-format immediate.
    // ------------------------------------------------------------------
    logic [31:0] w_addr_sum;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_rel;

    assign w_addr_sum = w_rs1_val +
                        ((w_opcode == c_OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_rel   = r_pc + ((w_opcode == c_OPC_JAL) ? w_imm_j : w_imm_b);

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    logic w_branch_cond;

    always_comb begin
        w_branch_cond = 1'b0;
        case (w_funct3)
            c_F3_BEQ:  w_branch_cond = (w_rs1_val == w_rs2_val);
            c_F3_BNE:  w_branch_cond = (w_rs1_val != w_rs2_val);
            c_F3_BLT:  w_branch_cond = ($signed(w_rs1_val) < $signed(w_rs2_val));
            c_F3_BGE:  w_branch_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            c_F3_BLTU: w_branch_cond = (w_rs1_val < w_rs2_val);
            c_F3_BGEU: w_branch_cond = (w_rs1_val >= w_rs2_val);
            default:   w_branch_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Main decode: ALU operands, write-back control and next PC
    // ------------------------------------------------------------------
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    alu_op_t     w_alu_op;
    logic [31:0] w_alu_result;
    wb_sel_t     w_wb_sel;
    logic        w_rd_we;
    logic        w_store;
    logic [31:0] w_pc_next;

    always_comb begin
        w_alu_a   = w_rs1_val;
        w_alu_b   = w_rs2_val;
        w_alu_op  = ALU_ADD;
        w_wb_sel  = WB_ALU;
        w_rd_we   = 1'b0;
        w_store   = 1'b0;
        w_pc_next = w_pc_plus4;

        case (w_opcode)
            c_OPC_LUI: begin
                w_alu_a = 32'd0;
                w_alu_b = w_imm_u;
                w_rd_we = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_alu_a = r_pc;
                w_alu_b = w_imm_u;
                w_rd_we = 1'b1;
            end
            c_OPC_JAL: begin
                w_wb_sel  = WB_PC4;
                w_rd_we   = 1'b1;
                w_pc_next = w_pc_rel;
            end
            c_OPC_JALR: begin
                if (w_funct3 == 3'b000) begin
                    w_wb_sel  = WB_PC4;
                    w_rd_we   = 1'b1;
                    w_pc_next = {w_addr_sum[31:1], 1'b0};
                end
            end
            c_OPC_BRANCH: begin
                if (w_branch_cond) begin
                    w_pc_next = w_pc_rel;
                end
            end
            c_OPC_LOAD: begin
                if (w_funct3 == c_F3_B || w_funct3 == c_F3_H ||
                    w_funct3 == c_F3_W || w_funct3 == c_F3_BU ||
                    w_funct3 == c_F3_HU) begin
                    w_wb_sel = WB_LOAD;
                    w_rd_we  = 1'b1;
                end
            end
            c_OPC_STORE: begin
                if (w_funct3 == c_F3_B || w_funct3 == c_F3_H ||
                    w_funct3 == c_F3_W) begin
                    w_store = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                // Only the shifts carry funct7; ADDI never becomes SUB.
                w_alu_b  = w_imm_i;
                w_alu_op = alu_op_decode(w_funct3,
                                         (w_funct3 == c_F3_SR) && w_funct7[5]);
                case (w_funct3)
                    c_F3_SLL: w_rd_we = (w_funct7 == c_F7_BASE);
                    c_F3_SR:  w_rd_we = (w_funct7 == c_F7_BASE) ||
                                        (w_funct7 == c_F7_ALT);
                    default:  w_rd_we = 1'b1;
                endcase
            end
            c_OPC_OP: begin
                if (w_funct7 == c_F7_MULDIV) begin
                    // Only MUL is implemented; the rest of M retires as NOP.
                    if (w_funct3 == c_F3_ADD_SUB) begin
                        w_alu_op = ALU_MUL;
                        w_rd_we  = 1'b1;
                    end
                end else if (w_funct7 == c_F7_BASE) begin
                    w_alu_op = alu_op_decode(w_funct3, 1'b0);
                    w_rd_we  = 1'b1;
                end else if (w_funct7 == c_F7_ALT &&
                             (w_funct3 == c_F3_ADD_SUB || w_funct3 == c_F3_SR)) begin
                    w_alu_op = alu_op_decode(w_funct3, 1'b1);
                    w_rd_we  = 1'b1;
                end
            end
            default: begin
                // FENCE, SYSTEM and unknown opcodes: PC+4, no side effects.
            end
        endcase
    end

    riscv_alu u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (w_alu_op),
        .o_result (w_alu_result)
    );

    // ------------------------------------------------------------------
    // Load lane extraction. Misaligned addresses are not trapped: halfword
    // accesses ignore addr[0] and word accesses ignore addr[1:0].
    // ------------------------------------------------------------------
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;

    assign w_lane_byte = data_rdata_i[{w_addr_sum[1:0], 3'b000} +: 8];
    assign w_lane_half = w_addr_sum[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

    always_comb begin
        w_load_data = data_rdata_i;
        case (w_funct3)
            c_F3_B:  w_load_data = {{24{w_lane_byte[7]}}, w_lane_byte};
            c_F3_H:  w_load_data = {{16{w_lane_half[15]}}, w_lane_half};
            c_F3_BU: w_load_data = {24'd0, w_lane_byte};
            c_F3_HU: w_load_data = {16'd0, w_lane_half};
            default: w_load_data = data_rdata_i;
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane steering: data is replicated so that the byte enables
    // alone select which lane the memory actually writes.
    // ------------------------------------------------------------------
    logic [31:0] w_store_data;
    logic [3:0]  w_store_we;

    always_comb begin
        w_store_data = w_rs2_val;
        w_store_we   = 4'b0000;
        if (w_store) begin
            case (w_funct3)
                c_F3_B: begin
                    w_store_data = {4{w_rs2_val[7:0]}};
                    w_store_we   = 4'b0001 << w_addr_sum[1:0];
                end
                c_F3_H: begin
                    w_store_data = {2{w_rs2_val[15:0]}};
                    w_store_we   = w_addr_sum[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_store_data = w_rs2_val;
                    w_store_we   = 4'b1111;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-back data
    // ------------------------------------------------------------------
    logic [31:0] w_wb_data;

    always_comb begin
        w_wb_data = w_alu_result;
        case (w_wb_sel)
            WB_PC4:  w_wb_data = w_pc_plus4;
            WB_LOAD: w_wb_data = w_load_data;
            default: w_wb_data = w_alu_result;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state. Reset takes priority over the write port, so an
    // instruction in flight when reset arrives leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_rd_we && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Write enables are gated combinationally so memory is never
    // written while reset is held, whatever sits at the fetch address.
    // ------------------------------------------------------------------
    assign instr_addr_o = r_pc;
    assign data_addr_o  = w_addr_sum;
    assign data_wdata_o = w_store_data;
    assign data_we_o    = rst ? w_store_we : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_riscv_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_cpu_core
//  Description : Directed bench for riscv_cpu_core. Programs store their
//                results to memory; expected stores are queued up front and a
//                negedge monitor compares every store the core issues. PC and
//                memory contents are checked directly by the stimulus thread.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_cpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_data_i;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_we_o;
    logic [31:0] data_rdata_i;

    always #5 clk = ~clk;

    riscv_cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_addr_o (instr_addr_o),
        .instr_data_i (instr_data_i),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_we_o    (data_we_o),
        .data_rdata_i (data_rdata_i)
    );

    // 1 KiB unified memory; programs at 0x000, data at 0x100 and above.
    logic [31:0] mem [0:255];

    assign instr_data_i = mem[instr_addr_o[9:2]];
    assign data_rdata_i = mem[data_addr_o[9:2]];

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                if (data_we_o[b]) mem[data_addr_o[9:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } store_t;

    store_t sb[$];
    store_t mon_got;
    store_t mon_exp;
    int     n_vec  = 0;
    int     n_fail = 0;

    always @(negedge clk) begin
        if (rst === 1'b1 && data_we_o !== 4'b0000) begin
            mon_got = '{addr: data_addr_o, we: data_we_o, wdata: data_wdata_o};
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_store: got addr=%h we=%b wdata=%h, required no store",
                         mon_got.addr, mon_got.we, mon_got.wdata);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL store: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                             mon_got.addr, mon_got.we, mon_got.wdata,
                             mon_exp.addr, mon_exp.we, mon_exp.wdata);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction encoders
    // ------------------------------------------------------------------
    function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] j_t(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return i_t(imm, rs1, 0, rd, 'h13);
    endfunction
    function automatic logic [31:0] sw(int rs2, int imm);
        return s_t(imm, rs2, 0, 2);
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic expect_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        sb.push_back('{addr: a, we: we, wdata: d});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d stores outstanding after %0d cycles, required 0",
                     name, sb.size(), budget);
            sb.delete();
        end
    endtask

    // Program A: x5*x6 by repeated addition, cross-checked against MUL.
    // The first store exposes x5 before it is written (0 after reset).
    task automatic load_prog_a();
        clear_mem();
        mem[0]  = sw(5, 'h100);
        mem[1]  = addi(5, 0, 5);
        mem[2]  = addi(6, 0, 3);
        mem[3]  = addi(7, 0, 0);
        mem[4]  = r_t('h00, 5, 7, 0, 7);      // 0x10 ADD x7,x7,x5
        mem[5]  = addi(8, 8, 1);
        mem[6]  = b_t(-8, 6, 8, 4);           // 0x18 BLT x8,x6,0x10
        mem[7]  = r_t('h01, 6, 5, 0, 9);      // 0x1C MUL x9,x5,x6
        mem[8]  = b_t(8, 9, 7, 1);            // 0x20 BNE x7,x9,0x28
        mem[9]  = sw(7, 'h104);
        mem[10] = j_t(0, 0);                  // 0x28 halt
    endtask

    // Program B: byte store/load lanes, branch signedness, R-type ALU ops.
    task automatic load_prog_b();
        clear_mem();
        mem[0]  = addi(1, 0, 'hAB);
        mem[1]  = s_t('h103, 1, 0, 0);        // SB x1,0x103
        mem[2]  = i_t('h103, 0, 0, 2, 'h03);  // LB x2
        mem[3]  = i_t('h103, 0, 4, 3, 'h03);  // LBU x3
        mem[4]  = sw(2, 'h110);
        mem[5]  = sw(3, 'h114);
        mem[6]  = addi(4, 0, -1);
        mem[7]  = addi(10, 0, 1);
        mem[8]  = b_t(8, 10, 4, 4);           // 0x20 BLT -1,1 -> 0x28
        mem[9]  = sw(4, 'h118);               // must be skipped
        mem[10] = b_t(8, 10, 4, 6);           // 0x28 BLTU -1,1 not taken
        mem[11] = sw(10, 'h11C);
        mem[12] = r_t('h20, 4, 10, 0, 5);     // SUB x5 = 1-(-1)
        mem[13] = r_t('h00, 10, 4, 4, 6);     // XOR
        mem[14] = r_t('h00, 10, 4, 2, 7);     // SLT
        mem[15] = r_t('h00, 10, 4, 3, 8);     // SLTU
        mem[16] = sw(5, 'h140);
        mem[17] = sw(6, 'h144);
        mem[18] = sw(7, 'h148);
        mem[19] = sw(8, 'h14C);
        mem[20] = j_t(0, 0);                  // 0x50 halt
    endtask

    // Program C: JAL/JALR (incl. rd == rs1), x0 discard, SRAI, SH/LH.
    task automatic load_prog_c();
        clear_mem();
        mem[0]  = addi(11, 0, 'h21);
        mem[1]  = j_t('h10, 0);               // 0x04 JAL x0 -> 0x14
        mem[5]  = i_t(0, 11, 0, 12, 'h67);    // 0x14 JALR x12,0(x11) -> 0x20
        mem[6]  = sw(0, 'h150);
        mem[7]  = sw(0, 'h150);
        mem[8]  = sw(12, 'h120);              // 0x20
        mem[9]  = addi(13, 0, 'h30);
        mem[10] = i_t(0, 13, 0, 13, 'h67);    // 0x28 JALR x13,0(x13) -> 0x30
        mem[11] = sw(0, 'h150);
        mem[12] = sw(13, 'h124);              // 0x30
        mem[13] = addi(0, 0, 5);
        mem[14] = r_t('h00, 0, 0, 0, 1);      // ADD x1,x0,x0
        mem[15] = sw(1, 'h128);
        mem[16] = u_t('h80000, 14, 'h37);     // LUI x14,0x80000
        mem[17] = i_t('h404, 14, 5, 15, 'h13);// SRAI x15,x14,4
        mem[18] = sw(15, 'h12C);
        mem[19] = s_t('h132, 11, 0, 1);       // SH x11,0x132
        mem[20] = i_t('h132, 0, 1, 16, 'h03); // LH x16,0x132
        mem[21] = sw(16, 'h134);
        mem[22] = j_t(0, 0);                  // 0x58 halt
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        // Reset hold: the word at 0 is a store, so the gated enables matter.
        load_prog_a();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check32("reset_pc", instr_addr_o, 32'h0);
            check32("reset_we", {28'd0, data_we_o}, 32'h0);
        end
        expect_store(32'h100, 4'b1111, 32'h0);
        expect_store(32'h104, 4'b1111, 32'd15);
        rst = 1'b1;
        check32("first_fetch", instr_addr_o, 32'h0);
        tick();
        check32("pc_after_first", instr_addr_o, 32'h4);
        wait_drain("mul_drain", 60);
        repeat (3) tick();
        check32("mul_halt_pc", instr_addr_o, 32'h28);
        check32("mul_mem104", mem[65], 32'd15);

        // Mid-run reset inside the loop, then a full rerun.
        mem[65] = 32'd0;
        rst = 1'b0;
        repeat (2) tick();
        expect_store(32'h100, 4'b1111, 32'h0);
        rst = 1'b1;
        repeat (8) tick();
        rst = 1'b0;
        tick();
        check32("midrst_pc", instr_addr_o, 32'h0);
        expect_store(32'h100, 4'b1111, 32'h0);   // x5 cleared by reset
        expect_store(32'h104, 4'b1111, 32'd15);
        rst = 1'b1;
        wait_drain("midrst_drain", 60);
        repeat (2) tick();
        check32("midrst_halt_pc", instr_addr_o, 32'h28);
        check32("midrst_mem104", mem[65], 32'd15);

        // Program B
        load_prog_b();
        rst = 1'b0;
        repeat (2) tick();
        expect_store(32'h103, 4'b1000, 32'hABAB_ABAB);
        expect_store(32'h110, 4'b1111, 32'hFFFF_FFAB);
        expect_store(32'h114, 4'b1111, 32'h0000_00AB);
        expect_store(32'h11C, 4'b1111, 32'h1);
        expect_store(32'h140, 4'b1111, 32'h2);
        expect_store(32'h144, 4'b1111, 32'hFFFF_FFFE);
        expect_store(32'h148, 4'b1111, 32'h1);
        expect_store(32'h14C, 4'b1111, 32'h0);
        rst = 1'b1;
        wait_drain("progb_drain", 60);
        repeat (2) tick();
        check32("progb_halt_pc", instr_addr_o, 32'h50);
        check32("sb_mem_word", mem[64], 32'hAB00_0000);

        // Program C
        load_prog_c();
        rst = 1'b0;
        repeat (2) tick();
        expect_store(32'h120, 4'b1111, 32'h18);
        expect_store(32'h124, 4'b1111, 32'h2C);
        expect_store(32'h128, 4'b1111, 32'h0);
        expect_store(32'h12C, 4'b1111, 32'hF800_0000);
        expect_store(32'h132, 4'b1100, 32'h0021_0021);
        expect_store(32'h134, 4'b1111, 32'h21);
        rst = 1'b1;
        repeat (2) tick();
        check32("jal_pc", instr_addr_o, 32'h14);
        tick();
        check32("jalr_pc", instr_addr_o, 32'h20);
        wait_drain("progc_drain", 60);
        repeat (2) tick();
        check32("progc_halt_pc", instr_addr_o, 32'h58);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/riscv_cpu_core.md
RISCV_CPU_CORE -- requirements
Module: riscv_cpu_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port instr_addr_o, output, 32 bits: byte address of the current instruction, equal to the PC.
REQ-005 SHALL have port instr_data_i, input, 32 bits: instruction word at instr_addr_o, returned combinationally.
REQ-006 SHALL have port data_addr_o, output, 32 bits: load/store byte address.
REQ-007 SHALL have port data_wdata_o, output, 32 bits: store data, byte-lane aligned.
REQ-008 SHALL have port data_we_o, output, 4 bits: per-byte write enables, where bit n writes bits [8n+7:8n].
REQ-009 SHALL have port data_rdata_i, input, 32 bits: word at data_addr_o with bits [1:0] ignored, returned combinationally.

Function
REQ-010 SHALL be a single-cycle RV32I core: fetch, decode, execute, memory access and register write-back all complete within one clk cycle; CPI = 1.
REQ-011 SHALL implement LUI, AUIPC, JAL, JALR, all six branches, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP instructions, and MUL (funct7 = 0000001, funct3 = 000, lower 32 bits of the product).
REQ-012 SHALL execute FENCE, ECALL, EBREAK, SYSTEM, other M-extension and unknown opcodes as NOPs: no register write, no memory write, PC+4.
REQ-013 SHALL provide a 32x32 register file with two combinational read ports and one write port written on posedge clk; x0 reads 0 and writes to it are discarded.
REQ-014 SHALL update the PC each cycle to PC+4, the branch/JAL target (PC+imm), or JALR (rs1+imm) with bit 0 cleared; all PC arithmetic wraps modulo 2^32.
REQ-015 SHALL write rd = PC+4 for JAL and JALR, using the pre-update rs1 value when rd == rs1.
REQ-016 SHALL compare BLT/BGE signed and BLTU/BGEU unsigned.
REQ-017 SHALL mask shift amounts to 5 bits; SRA/SRAI SHALL sign-fill.
REQ-018 SHALL drive data_addr_o = rs1 + sign-extended imm for every instruction; the value is don't-care for non-memory instructions.
REQ-019 SHALL, for stores: replicate the SB byte to all four lanes and set we = 0001 << addr[1:0]; replicate the SH halfword to both halves and set we = 0011 << {addr[1],0}; set we = 1111 for SW.
REQ-020 SHALL drive data_we_o = 0000 for all non-store instructions.
REQ-021 SHALL, for loads, select the byte/halfword lane by addr[1:0] and sign- or zero-extend it per funct3.
REQ-022 SHALL NOT detect or trap misaligned accesses: SH/LH ignore addr[0], and SW/LW ignore addr[1:0].
REQ-023 SHALL NOT raise exceptions or interrupts.

Reset
REQ-024 SHALL, while rst = 0 at a posedge, load PC = RESET_PC and clear all registers x1-x31 to 0.
REQ-025 SHALL force data_we_o = 0000 combinationally while rst = 0.
REQ-026 SHALL execute the instruction at RESET_PC on the first posedge after rst returns to 1.
REQ-027 SHALL abandon the current instruction when reset is asserted mid-program, with no partial register write.

Structure
REQ-028 SHALL place the opcode, funct3, funct7 and ALU-operation constants, plus the ALU-op enumerated typedef, in the shared package riscv_pkg.
REQ-029 SHALL contain exactly one sub-module, riscv_alu: combinational, operands a and b, op code, 32-bit result, covering ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND/MUL.
REQ-030 SHALL keep decode, immediate generation, the register file, PC logic and load/store lane logic in the top module.

Verification
REQ-031 Reset: hold rst = 0 for 5 cycles -> instr_addr_o = 0 and data_we_o = 0000 throughout; first fetch is from address 0 after release.
REQ-032 Multiply loop: x5 = 5, x6 = 3, repeated-add loop plus MUL check, SW result to 0x104, halt with JAL x0,0 at 0x28 -> Mem[0x104] = 15 and instr_addr_o stays 0x28.
REQ-033 Byte store/load: SB of 0xAB to 0x103 -> we = 1000 and wdata[31:24] = 0xAB; LB from 0x103 -> rd = 0xFFFFFFAB; LBU from 0x103 -> rd = 0x000000AB.
REQ-034 Branches and jumps: BLT -1,1 taken; BLTU -1,1 not taken; JALR to 0x21 -> PC = 0x20 and rd = old PC+4.
REQ-035 x0 and shifts: ADDI x0,x0,5 then ADD x1,x0,x0 -> x1 = 0; SRAI 0x80000000 by 4 -> 0xF8000000.
REQ-036 Mid-run reset: assert rst = 0 during the multiply loop -> PC = 0 next cycle and x5 = 0; the program then reruns to Mem[0x104] = 15.
